// File: rtl/mac_pkg.sv
// Shared FSM state encoding and MAC array instruction encodings for the
// column-array sequencer.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_ctrl_perf_cnt.sv
// Saturating 16-bit busy-cycle counter; clear has priority over increment.
// Exists only when MAC_ARRAY_CTRL_PERF_EN is defined, so default builds carry no counter.
`ifdef MAC_ARRAY_CTRL_PERF_EN
module mac_ctrl_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 16'h0000;
    end else if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/mac_array_ctrl.sv
// Sequencer for the MAC column array: clear, key load, query execute, drain, done.
// Optional run-length counter under MAC_ARRAY_CTRL_PERF_EN; every output is a flop.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int col   = 8,
  parameter int k_aw  = 3,
  parameter int q_aw  = 4,
  parameter int drain = col + 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [q_aw:0]   num_q,
  input  logic            ofifo_afull,
  output logic            kmem_rd,
  output logic [k_aw-1:0] kmem_addr,
  output logic            qmem_rd,
  output logic [q_aw-1:0] qmem_addr,
  output logic            arr_rst,
  output logic [1:0]      inst,
  output logic            busy,
  output logic            done,
  output logic [15:0]     perf_cycles
);

  localparam int DW = (drain < 1) ? 1 : $clog2(drain + 1);
  localparam logic [k_aw-1:0] K_LAST = k_aw'(col - 1);
  localparam logic [DW-1:0]   D_LAST = DW'(drain);

  state_e          state_q, state_d;
  logic [q_aw:0]   num_q_q, num_q_d;
  logic            krd_q, krd_d;
  logic [k_aw-1:0] kaddr_q, kaddr_d;
  logic            qrd_q, qrd_d;
  logic [q_aw-1:0] qaddr_q, qaddr_d;
  logic            arst_q, arst_d;
  logic [1:0]      inst_q, inst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [q_aw:0]   q_end;
  logic            q_last;

  // Exit compare is one bit wider than the address so num_q = 2^q_aw works.
  assign q_end  = num_q_q - {{q_aw{1'b0}}, 1'b1};
  assign q_last = ({1'b0, qaddr_q} == q_end);

  always_comb begin
    state_d = state_q;
    num_q_d = num_q_q;
    krd_d   = 1'b0;
    kaddr_d = '0;
    qrd_d   = 1'b0;
    qaddr_d = '0;
    dcnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          num_q_d = num_q;
        end
      end
      CLR: begin
        state_d = LOAD;
        krd_d   = 1'b1;
      end
      LOAD: begin
        if (kaddr_q == K_LAST) begin
          if (num_q_q == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = EXEC;
            qrd_d   = 1'b1;
          end
        end else begin
          krd_d   = 1'b1;
          kaddr_d = kaddr_q + k_aw'(1);
        end
      end
      EXEC: begin
        if (qrd_q && q_last) begin
          state_d = DRAIN;
        end else begin
          // A stalled slot keeps the address of the query still owed.
          qrd_d   = !ofifo_afull;
          qaddr_d = qrd_q ? (qaddr_q + q_aw'(1)) : qaddr_q;
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          state_d = DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    arst_d = (state_d == CLR);
    busy_d = (state_d == CLR) || (state_d == LOAD) || (state_d == EXEC) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    inst_d = krd_q ? INST_LOAD : (qrd_q ? INST_EXEC : INST_NOP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      num_q_q <= '0;
      krd_q   <= 1'b0;
      kaddr_q <= '0;
      qrd_q   <= 1'b0;
      qaddr_q <= '0;
      arst_q  <= 1'b0;
      inst_q  <= INST_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q_q <= num_q_d;
      krd_q   <= krd_d;
      kaddr_q <= kaddr_d;
      qrd_q   <= qrd_d;
      qaddr_q <= qaddr_d;
      arst_q  <= arst_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign kmem_rd   = krd_q;
  assign kmem_addr = kaddr_q;
  assign qmem_rd   = qrd_q;
  assign qmem_addr = qaddr_q;
  assign arr_rst   = arst_q;
  assign inst      = inst_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MAC_ARRAY_CTRL_PERF_EN
  mac_ctrl_perf_cnt u_perf (
    .clk   (clk),
    .reset (reset),
    .clr_i (arst_q),
    .inc_i (busy_q),
    .cnt_o (perf_cycles)
  );
`else
  assign perf_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed and randomized runs of mac_array_ctrl checked cycle by cycle against
// a schedule model built from the run-length and stall rules.
module tb_mac_array_ctrl;

  localparam int COL  = 8;
  localparam int KAW  = 3;
  localparam int QAW  = 4;
  localparam int NQW  = QAW + 1;
  localparam int DRN  = COL + 7;
  localparam int MAXK = 256;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [NQW-1:0] num_q = '0;
  logic           ofifo_afull = 1'b0;
  logic           kmem_rd;
  logic [KAW-1:0] kmem_addr;
  logic           qmem_rd;
  logic [QAW-1:0] qmem_addr;
  logic           arr_rst;
  logic [1:0]     inst;
  logic           busy;
  logic           done;
  logic [15:0]    perf_cycles;

  int n_cmp  = 0;
  int n_fail = 0;
  int perf_prev = 0;
  int done_off  = 0;

  bit             af     [MAXK];
  bit             e_krd  [MAXK];
  bit             e_qrd  [MAXK];
  bit             e_arst [MAXK];
  bit             e_busy [MAXK];
  bit             e_done [MAXK];
  logic [KAW-1:0] e_kad  [MAXK];
  logic [QAW-1:0] e_qad  [MAXK];
  logic [1:0]     e_ins  [MAXK];

  mac_array_ctrl #(
    .col   (COL),
    .k_aw  (KAW),
    .q_aw  (QAW),
    .drain (DRN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_q       (num_q),
    .ofifo_afull (ofifo_afull),
    .kmem_rd     (kmem_rd),
    .kmem_addr   (kmem_addr),
    .qmem_rd     (qmem_rd),
    .qmem_addr   (qmem_addr),
    .arr_rst     (arr_rst),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .perf_cycles (perf_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] snap();
    return {kmem_rd, kmem_addr, qmem_rd, qmem_addr, arr_rst, inst, busy, done, perf_cycles};
  endfunction

  task automatic chk(input string tag, input int k, input logic [29:0] obs, input logic [29:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Counter is zero after the CLR cycle, then counts each remaining busy cycle.
  function automatic logic [15:0] perf_exp(input int k);
`ifdef MAC_ARRAY_CTRL_PERF_EN
    int v;
    if (k <= 1) v = perf_prev;
    else if (k - 2 < done_off - 2) v = k - 2;
    else v = done_off - 2;
    if (v > 65535) v = 65535;
    return 16'(v);
`else
    return 16'h0000;
`endif
  endfunction

  // Expected schedule, offsets relative to the cycle in which start is sampled.
  task automatic build(input int nq);
    int c;
    int last;
    for (int k = 0; k < MAXK; k++) begin
      e_krd[k] = 0; e_qrd[k] = 0; e_arst[k] = 0; e_busy[k] = 0; e_done[k] = 0;
      e_kad[k] = '0; e_qad[k] = '0; e_ins[k] = 2'b00;
    end
    e_arst[1] = 1;
    for (int i = 0; i < COL; i++) begin
      e_krd[2 + i] = 1;
      e_kad[2 + i] = KAW'(i);
      e_ins[3 + i] = 2'b01;
    end
    c = 2 + COL;
    last = 1 + COL;
    for (int j = 0; j < nq; j++) begin
      while (j > 0 && af[c - 1]) begin
        e_qad[c] = QAW'(j);
        c++;
      end
      e_qrd[c] = 1;
      e_qad[c] = QAW'(j);
      e_ins[c + 1] = 2'b10;
      last = c;
      c++;
    end
    done_off = last + 2 + DRN;
    for (int k = 1; k < done_off; k++) e_busy[k] = 1;
    e_done[done_off] = 1;
  endtask

  task automatic run(input string tag, input int nq, input bit rnd_af, input bit dir_stall,
                     input bit extra_start, input int abort_at);
    for (int k = 0; k < MAXK; k++) af[k] = rnd_af && (k < 120) && ($urandom_range(0, 3) == 0);
    if (dir_stall) begin
      for (int k = COL + 3; k <= COL + 5; k++) af[k] = 1;
      for (int k = 20; k <= 28; k++) af[k] = 1;
    end
    build(nq);
    for (int k = 0; k <= done_off + 1; k++) begin
      @(negedge clk);
      chk(tag, k, snap(), {e_krd[k], e_kad[k], e_qrd[k], e_qad[k], e_arst[k], e_ins[k],
                           e_busy[k], e_done[k], perf_exp(k)});
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        chk({tag, "_rst_now"}, k, snap(), '0);
        start = 1'b0;
        ofifo_afull = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_rst_hold"}, k, snap(), '0);
        reset = 1'b1;
        perf_prev = 0;
        return;
      end
      start = (k == 0) || (extra_start && (k == 4 || k == done_off - 4));
      num_q = (k == 0) ? NQW'(nq) : NQW'($urandom);
      ofifo_afull = af[k];
    end
`ifdef MAC_ARRAY_CTRL_PERF_EN
    perf_prev = done_off - 2;
`else
    perf_prev = 0;
`endif
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk("reset_state", 0, snap(), '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run("basic",      4,  1'b0, 1'b0, 1'b0, -1);
    run("zero_q",     0,  1'b0, 1'b0, 1'b0, -1);
    run("stall",      4,  1'b0, 1'b1, 1'b0, -1);
    run("start_ign",  4,  1'b0, 1'b0, 1'b1, -1);
    run("max_q",      16, 1'b1, 1'b0, 1'b0, -1);
    run("abort",      6,  1'b0, 1'b0, 1'b0, COL + 4);
    run("after_rst",  4,  1'b0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      run("rand", $urandom_range(0, 16), 1'b1, 1'b0, r[0], -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the MAC column array. It clears the array, streams one key vector per column from key memory (load phase), then streams a programmable number of query vectors from query memory (execute phase), and waits for the column pipelines to drain into the output FIFO before it signals done. It sits between the key/query SRAMs, the MAC array `i_inst`/`q_in`/`reset` inputs, and the output-FIFO status.

## Interface
- `col`, 8: number of MAC columns; one key vector is loaded per column.
- `k_aw`, 3: key-memory address width; must satisfy 2^`k_aw` ≥ `col`.
- `q_aw`, 4: query-memory address width.
- `drain`, 15: cycles to wait after the last execute instruction. The default is `col` + 7: 1 cycle of instruction register, 6 cycles of column pipeline, plus the column chaining skew.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse that starts a run; sampled only in IDLE.
- `num_q`  in  `q_aw`+1  number of queries to execute; latched on `start`.
- `ofifo_afull`  in  1  output FIFO almost full; stalls query issue.
- `kmem_rd`  out  1  key-memory read enable.
- `kmem_addr`  out  `k_aw`  key-memory read address.
- `qmem_rd`  out  1  query-memory read enable.
- `qmem_addr`  out  `q_aw`  query-memory read address.
- `arr_rst`  out  1  synchronous active-high reset to the MAC array.
- `inst`  out  2  array instruction; bit [1] = execute, bit [0] = load.
- `busy`  out  1  high from CLR through DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `perf_cycles`  out  16  run-length counter (see Configuration).

## Operation
- State sequence: IDLE → CLR → LOAD → EXEC → DRAIN → DONE → IDLE.
- **IDLE**
  - All outputs are 0.
  - `start`=1 latches `num_q` and moves to CLR.
- **CLR**
  - Drives `arr_rst`=1 for exactly 1 cycle. This rearms each column's key-capture logic.
  - Moves to LOAD.
- **LOAD**
  - Runs for `col` cycles with `kmem_rd`=1 and `kmem_addr` = 0 … `col`-1.
  - Not stallable.
  - Moves to EXEC after address `col`-1 is issued.
- **EXEC**
  - On each cycle with `ofifo_afull`=0: `qmem_rd`=1, `qmem_addr` increments from 0.
  - On each cycle with `ofifo_afull`=1: `qmem_rd`=0 and the address holds.
  - Moves to DRAIN after address `num_q`-1 is issued.
  - If the latched `num_q` = 0, EXEC is skipped and LOAD goes directly to DRAIN.
- **DRAIN**
  - Counts `drain` cycles, then moves to DONE.
  - `ofifo_afull` is ignored in this state.
- **DONE**
  - `done`=1 for 1 cycle, then returns to IDLE.
- **Instruction alignment:** `inst[0]` is `kmem_rd` delayed 1 cycle, and `inst[1]` is `qmem_rd` delayed 1 cycle. This aligns each instruction with the 1-cycle SRAM read data. `inst` is never 2'b11.
- **`start` outside IDLE** is ignored.
- **Asynchronous reset** (`reset`=0, including mid-run):
  - FSM returns to IDLE.
  - Address counters, `inst`, `done`, `busy`, `arr_rst`, `kmem_rd`, `qmem_rd` are forced to 0 immediately.
  - `perf_cycles` is cleared to 0.
  - No partial-run completion is signalled.

## Timing
- Cycle numbering, with `start` sampled in cycle t:
  - CLR in t+1.
  - LOAD in t+2 … t+1+`col`.
  - `inst`=01 in t+3 … t+2+`col`.
  - First execute read in t+2+`col`; its `inst`=10 appears one cycle later.
- **Unstalled run length:** `done` is asserted at cycle t+3+`col`+`num_q`+`drain`.
- **Stalls:** each `ofifo_afull` cycle in EXEC adds exactly 1 cycle to the run.
- **Output registration:** all outputs are registered. The only combinational path is `ofifo_afull` → next-state/address logic; it does not reach the outputs combinationally.
- **Counter wrap:** address counters never wrap within a run. The EXEC exit compare uses `q_aw`+1 bits so that `num_q` = 2^`q_aw` is legal.

## Configuration
- Macro: `MAC_ARRAY_CTRL_PERF_EN`.
- **When defined:**
  - `perf_cycles` clears on the CLR cycle.
  - It increments every cycle while `busy`=1 and saturates at 16'hFFFF.
  - It holds its value through IDLE until the next run.
- **When undefined:**
  - `perf_cycles` is tied to 0.
  - No counter logic is synthesized.

## Structure
- Shared package `mac_pkg`:
  - FSM state enum (IDLE, CLR, LOAD, EXEC, DRAIN, DONE).
  - Instruction constants `INST_NOP`=2'b00, `INST_LOAD`=2'b01, `INST_EXEC`=2'b10.
- One sub-module, `mac_ctrl_perf_cnt`: the saturating 16-bit busy-cycle counter, instantiated only under `MAC_ARRAY_CTRL_PERF_EN`.

## Test plan
- **Basic run:** `col`=8, `num_q`=4, `start` pulse.
  - `kmem_addr` 0..7 on consecutive cycles, then `qmem_addr` 0..3.
  - `inst` = 8×01 then 4×10, each 1 cycle after its read.
  - `done` at t+3+8+4+15 = t+30.
- **Zero queries:** `num_q`=0.
  - No `qmem_rd` and no `inst`=10.
  - `done` at t+26.
- **Stall:** `num_q`=4 with `ofifo_afull` high for 3 cycles after the second query.
  - `qmem_addr` holds at 2 for those 3 cycles.
  - `done` delayed by exactly 3 cycles.
  - `ofifo_afull` high during DRAIN has no effect.
- **Start ignored:** `start` pulsed during LOAD and during DRAIN.
  - No restart.
  - Exactly one `done`.
- **Mid-run reset:** `reset` low during EXEC.
  - All outputs are 0 while `reset` is low, before any clock edge.
  - After release, the FSM is in IDLE and a new `start` runs normally, including the CLR pulse.
- **Performance counter:** with the macro defined, a basic run leaves `perf_cycles` = 28.
  - With the macro undefined, `perf_cycles` = 0 throughout.
